glb_ld_dma_addr_gen: RTL

//  Load-DMA address generator for one GLB tile. Pops one dma_ld_header_t from the load header queue
//  and walks its LOOP_LEVEL-deep nested iteration space, emitting one rdrq_packet_t per CGRA word.

---
 rtl/global_buffer_pkg.sv | 56 +++++
 rtl/glb_ld_dma_addr_gen_if.sv | 41 ++++
 rtl/glb_loop_iter.sv | 87 ++++++++
 rtl/glb_ld_dma_addr_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/global_buffer_pkg.sv
// ---------------------------------------------------------------------------
// global_buffer_pkg
// Shared widths and packet types for the global buffer tile. The load-DMA
// address generator uses the header, loop control and read-request packets
// defined here, plus its own three-state FSM enum.
// Contents:
//   LOOP_LEVEL, GLB_ADDR_WIDTH, MAX_RANGE_WIDTH, MAX_STRIDE_WIDTH,
//   MAX_NUM_WORDS_WIDTH    widths shared across the tile
//   loop_ctrl_t            one loop level: range (iterations) and stride (16-bit words)
//   dma_ld_header_t        one load-DMA job as it sits in the header queue
//   rdrq_packet_t          read request towards the bank mux
//   ld_dma_state_e         IDLE / ACTIVE / INACTIVE
//   effRange()             maps a zero range to one so unused levels iterate once
// ---------------------------------------------------------------------------
package global_buffer_pkg;

  localparam int LOOP_LEVEL          = 4;
  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int MAX_RANGE_WIDTH     = 21;
  localparam int MAX_STRIDE_WIDTH    = 11;
  localparam int MAX_NUM_WORDS_WIDTH = 21;

  localparam logic [MAX_RANGE_WIDTH-1:0] RANGE_ONE = 1;

  typedef struct packed {
    logic [MAX_RANGE_WIDTH-1:0]  rng;
    logic [MAX_STRIDE_WIDTH-1:0] stride;
  } loop_ctrl_t;

  typedef struct packed {
    logic                             valid;
    logic [GLB_ADDR_WIDTH-1:0]        start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0]   num_active_words;
    logic [MAX_NUM_WORDS_WIDTH-1:0]   num_inactive_words;
    loop_ctrl_t [LOOP_LEVEL-1:0]      loop_ctrl;
  } dma_ld_header_t;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    INACTIVE
  } ld_dma_state_e;

  // A range of zero means "level unused", which behaves exactly like a
  // single iteration, so every level can be walked uniformly.
  function automatic logic [MAX_RANGE_WIDTH-1:0] effRange(input logic [MAX_RANGE_WIDTH-1:0] r);
    if (r == '0) return RANGE_ONE;
    else         return r;
  endfunction

endpackage

// File: rtl/glb_ld_dma_addr_gen_if.sv
// ---------------------------------------------------------------------------
// glb_ld_dma_addr_gen_if
// Bundles the load-DMA address generator's queue, stall and request signals.
//   ld_hdr        header at the head of the load queue (valid = available)
//   ld_hdr_pop    header consumed this cycle
//   rd_stall      downstream back-pressure
//   rdrq          read request (rd_en + byte address)
//   ld_done_pulse one-cycle pulse when a header has been fully issued
//   busy          generator is working on a header
// Modports: master = queue/bank side (drives header and stall),
//           slave  = the address generator.
// ---------------------------------------------------------------------------
interface glb_ld_dma_addr_gen_if;
  import global_buffer_pkg::*;

  dma_ld_header_t ld_hdr;
  logic           ld_hdr_pop;
  logic           rd_stall;
  rdrq_packet_t   rdrq;
  logic           ld_done_pulse;
  logic           busy;

  modport master (
    output ld_hdr,
    output rd_stall,
    input  ld_hdr_pop,
    input  rdrq,
    input  ld_done_pulse,
    input  busy
  );

  modport slave (
    input  ld_hdr,
    input  rd_stall,
    output ld_hdr_pop,
    output rdrq,
    output ld_done_pulse,
    output busy
  );

endinterface

// File: rtl/glb_loop_iter.sv
// ---------------------------------------------------------------------------
// glb_loop_iter
// Generic nested-loop walker. Keeps an iterator and a running offset per
// level and steps them without multipliers: the lowest level that has not
// reached its end increments, and every level below it restarts at zero
// carrying that level's new offset.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   i_clear       restart the walk (all itr/off to zero)
//   i_advance     step to the next point of the iteration space
//   i_range       effective range per level (must be >= 1)
//   i_stride      stride per level
//   o_last        the current point is the final one
//   o_offset      offset of the current point (level-0 offset)
// ---------------------------------------------------------------------------
module glb_loop_iter #(
  parameter int NUM_LEVELS   = 4,
  parameter int RANGE_WIDTH  = 21,
  parameter int STRIDE_WIDTH = 11,
  parameter int OFF_WIDTH    = 21
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    i_clear,
  input  logic                                    i_advance,
  input  logic [NUM_LEVELS-1:0][RANGE_WIDTH-1:0]  i_range,
  input  logic [NUM_LEVELS-1:0][STRIDE_WIDTH-1:0] i_stride,
  output logic                                    o_last,
  output logic [OFF_WIDTH-1:0]                    o_offset
);

  localparam logic [RANGE_WIDTH-1:0] ITR_ONE = 1;

  logic [NUM_LEVELS-1:0][RANGE_WIDTH-1:0] r_itr;
  logic [NUM_LEVELS-1:0][OFF_WIDTH-1:0]   r_off;
  logic [NUM_LEVELS-1:0]                  w_isStep;
  logic [NUM_LEVELS-1:0]                  w_isBelow;
  logic [OFF_WIDTH-1:0]                   w_newOff;
  logic                                   w_found;

  // Scan from level 0 upward for the first level still short of its end.
  // Levels passed over on the way (all at their end) will wrap to zero,
  // and they inherit the stepping level's updated offset.
  always_comb begin
    w_found   = 1'b0;
    w_isStep  = '0;
    w_isBelow = '0;
    w_newOff  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (!w_found) begin
        if (r_itr[i] == i_range[i] - ITR_ONE) begin
          w_isBelow[i] = 1'b1;
        end else begin
          w_found     = 1'b1;
          w_isStep[i] = 1'b1;
          w_newOff    = r_off[i] + {{(OFF_WIDTH-STRIDE_WIDTH){1'b0}}, i_stride[i]};
        end
      end
    end
  end

  assign o_last   = !w_found;
  assign o_offset = r_off[0];

  // Iterator/offset registers. Stepping past the final point leaves them
  // untouched; the owner restarts the walk with i_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_itr <= '0;
      r_off <= '0;
    end else if (i_clear) begin
      r_itr <= '0;
      r_off <= '0;
    end else if (i_advance && w_found) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (w_isStep[i]) begin
          r_itr[i] <= r_itr[i] + ITR_ONE;
          r_off[i] <= w_newOff;
        end else if (w_isBelow[i]) begin
          r_itr[i] <= '0;
          r_off[i] <= w_newOff;
        end
      end
    end
  end

endmodule

// File: rtl/glb_ld_dma_addr_gen.sv
// ---------------------------------------------------------------------------
// glb_ld_dma_addr_gen
// Load-DMA address generator for one GLB tile. Pops a header from the load
// header queue, walks its nested loop space and issues one read request per
// CGRA word, optionally duty-cycling between active bursts and idle gaps,
// and pulses done once the header is fully issued.
// Widths come from global_buffer_pkg (LOOP_LEVEL, GLB_ADDR_WIDTH, ...).
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   dma_if   slave side of glb_ld_dma_addr_gen_if
//            (ld_hdr, ld_hdr_pop, rd_stall, rdrq, ld_done_pulse, busy)
// ---------------------------------------------------------------------------
module glb_ld_dma_addr_gen
  import global_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  glb_ld_dma_addr_gen_if.slave  dma_if
);

  localparam int OFF_WIDTH = GLB_ADDR_WIDTH - 1;
  localparam logic [MAX_NUM_WORDS_WIDTH-1:0] WORDS_ONE = 1;

  ld_dma_state_e                              r_state;
  ld_dma_state_e                              w_nextState;
  logic [GLB_ADDR_WIDTH-1:1]                  r_startWord;
  logic [MAX_NUM_WORDS_WIDTH-1:0]             r_numActive;
  logic [MAX_NUM_WORDS_WIDTH-1:0]             r_numInactive;
  loop_ctrl_t [LOOP_LEVEL-1:0]                r_loopCtrl;
  logic [MAX_NUM_WORDS_WIDTH-1:0]             r_activeCnt;
  logic [MAX_NUM_WORDS_WIDTH-1:0]             r_inactiveCnt;
  logic [GLB_ADDR_WIDTH-1:0]                  r_lastAddr;
  logic                                       r_done;

  logic                                       w_pop;
  logic                                       w_issue;
  logic                                       w_last;
  logic                                       w_dutyEn;
  logic [OFF_WIDTH-1:0]                       w_offset;
  logic [GLB_ADDR_WIDTH-1:0]                  w_issueAddr;
  logic [LOOP_LEVEL-1:0][MAX_RANGE_WIDTH-1:0] w_rng;
  logic [LOOP_LEVEL-1:0][MAX_STRIDE_WIDTH-1:0] w_stride;

  // Unused levels (range 0) are presented to the walker as range 1.
  always_comb begin
    w_rng    = '0;
    w_stride = '0;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      w_rng[i]    = effRange(r_loopCtrl[i].rng);
      w_stride[i] = r_loopCtrl[i].stride;
    end
  end

  glb_loop_iter #(
    .NUM_LEVELS   (LOOP_LEVEL),
    .RANGE_WIDTH  (MAX_RANGE_WIDTH),
    .STRIDE_WIDTH (MAX_STRIDE_WIDTH),
    .OFF_WIDTH    (OFF_WIDTH)
  ) u_loop_iter (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_pop),
    .i_advance (w_issue),
    .i_range   (w_rng),
    .i_stride  (w_stride),
    .o_last    (w_last),
    .o_offset  (w_offset)
  );

  // Offsets count 16-bit words, so the byte address is the even-aligned
  // start plus twice the offset; the sum wraps at the address width.
  assign w_issueAddr = {r_startWord, 1'b0} + {w_offset, 1'b0};
  assign w_dutyEn    = (r_numActive != '0) && (r_numInactive != '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next state plus the pop/issue strobes. A pop is held off during the
  // done cycle so back-to-back headers always see a one-cycle bubble.
  // When the final word also fills the active quota, finishing wins.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = dma_if.ld_hdr.valid && !r_done;
        if (w_pop) w_nextState = ACTIVE;
      end
      ACTIVE: begin
        if (!dma_if.rd_stall) begin
          w_issue = 1'b1;
          if (w_last)
            w_nextState = IDLE;
          else if (w_dutyEn && (r_activeCnt == r_numActive - WORDS_ONE))
            w_nextState = INACTIVE;
        end
      end
      INACTIVE: begin
        if (r_inactiveCnt == r_numInactive - WORDS_ONE) w_nextState = ACTIVE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Header latch, duty-cycle counters, held address and the done pulse.
  // The inactive counter runs every cycle in INACTIVE, stall or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_startWord   <= '0;
      r_numActive   <= '0;
      r_numInactive <= '0;
      r_loopCtrl    <= '0;
      r_activeCnt   <= '0;
      r_inactiveCnt <= '0;
      r_lastAddr    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_issue && w_last;
      if (w_pop) begin
        r_startWord   <= dma_if.ld_hdr.start_addr[GLB_ADDR_WIDTH-1:1];
        r_numActive   <= dma_if.ld_hdr.num_active_words;
        r_numInactive <= dma_if.ld_hdr.num_inactive_words;
        r_loopCtrl    <= dma_if.ld_hdr.loop_ctrl;
        r_activeCnt   <= '0;
        r_inactiveCnt <= '0;
      end
      if (w_issue) begin
        r_lastAddr <= w_issueAddr;
        if (w_nextState == INACTIVE) r_activeCnt <= '0;
        else                         r_activeCnt <= r_activeCnt + WORDS_ONE;
      end
      if (r_state == INACTIVE) begin
        if (w_nextState == ACTIVE) r_inactiveCnt <= '0;
        else                       r_inactiveCnt <= r_inactiveCnt + WORDS_ONE;
      end
    end
  end

  assign dma_if.ld_hdr_pop    = w_pop;
  assign dma_if.rdrq.rd_en    = w_issue;
  assign dma_if.rdrq.rd_addr  = w_issue ? w_issueAddr : r_lastAddr;
  assign dma_if.ld_done_pulse = r_done;
  assign dma_if.busy          = (r_state != IDLE);

endmodule
